brick_grid_collider: RTL and testbench

//  Parametrised ROWS x COLS brick-wall collision engine for the breakout game path. Once per

---
 rtl/brick_grid_collider_pkg.sv | 21 ++
 rtl/brick_grid_collider_if.sv | 10 +
 rtl/brick_coord_gen.sv | 50 +++++
 rtl/brick_grid_collider.sv | 130 +++++++++++++
 tb/tb_brick_grid_collider.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/brick_grid_collider_pkg.sv
// brick_grid_collider_pkg: geometry defaults, hit-side encodings and shared types for the brick wall
package brick_grid_collider_pkg;
   localparam int CORD_W = 12;
   localparam int DEPTH_W = CORD_W + 1;
   localparam int DEF_ROWS = 4;
   localparam int DEF_COLS = 4;
   localparam int DEF_ORIGIN_X = 100;
   localparam int DEF_ORIGIN_Y = 80;
   localparam int DEF_B_WIDTH = 100;
   localparam int DEF_B_HEIGHT = 30;
   localparam int DEF_GAP_X = 20;
   localparam int DEF_GAP_Y = 10;
   localparam int DEF_BALL_SIZE = 8;
   localparam logic [1:0] HIT_SIDE_TB = 2'b01;
   localparam logic [1:0] HIT_SIDE_LR = 2'b10;
   localparam logic [1:0] HIT_SIDE_CORNER = 2'b11;
   typedef enum logic [1:0] {IDLE, SCAN, HIT} state_t;
   function automatic logic [1:0] side_of(input logic [DEPTH_W-1:0] dx, input logic [DEPTH_W-1:0] dy);
      return dx > dy ? HIT_SIDE_TB : dx < dy ? HIT_SIDE_LR : HIT_SIDE_CORNER;
   endfunction
endpackage

// File: rtl/brick_grid_collider_if.sv
// brick_grid_collider_if: hit report valid/ready channel from the collider to the ball logic
interface brick_grid_collider_if #(parameter int RW = 2, parameter int CW = 2);
   logic hit_valid;
   logic hit_ready;
   logic [RW-1:0] hit_row;
   logic [CW-1:0] hit_col;
   logic [1:0] hit_side;
   modport master(output hit_valid, output hit_row, output hit_col, output hit_side, input hit_ready);
   modport slave(input hit_valid, input hit_row, input hit_col, input hit_side, output hit_ready);
endinterface

// File: rtl/brick_coord_gen.sv
// brick_coord_gen: row-major brick walker producing index, row/col and top-left corner with adders only
module brick_coord_gen
   import brick_grid_collider_pkg::*;
#(
   parameter int ROWS = 4,
   parameter int COLS = 4,
   parameter int ORIGIN_X = 100,
   parameter int ORIGIN_Y = 80,
   parameter int PITCH_X = 120,
   parameter int PITCH_Y = 40,
   parameter int RW = 2,
   parameter int CW = 2,
   parameter int IW = 4
) (
   input logic pclk,
   input logic rst_n,
   input logic start,
   input logic step,
   output logic [RW-1:0] row,
   output logic [CW-1:0] col,
   output logic [IW-1:0] idx,
   output logic [CORD_W-1:0] x0,
   output logic [CORD_W-1:0] y0,
   output logic last
);
   logic col_end;
   assign col_end = col == CW'(COLS - 1);
   assign last = col_end && row == RW'(ROWS - 1);
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         row <= '0;
         col <= '0;
         idx <= '0;
         x0 <= CORD_W'(ORIGIN_X);
         y0 <= CORD_W'(ORIGIN_Y);
      end else if (start) begin
         row <= '0;
         col <= '0;
         idx <= '0;
         x0 <= CORD_W'(ORIGIN_X);
         y0 <= CORD_W'(ORIGIN_Y);
      end else if (step) begin
         idx <= idx + IW'(1);
         col <= col_end ? '0 : col + CW'(1);
         row <= col_end ? row + RW'(1) : row;
         x0 <= col_end ? CORD_W'(ORIGIN_X) : x0 + CORD_W'(PITCH_X);
         y0 <= col_end ? y0 + CORD_W'(PITCH_Y) : y0;
      end
   end
endmodule

// File: rtl/brick_grid_collider.sv
// brick_grid_collider: per-frame scan of the brick wall against the ball box, reporting one hit per frame
module brick_grid_collider
   import brick_grid_collider_pkg::*;
#(
   parameter int ROWS = DEF_ROWS,
   parameter int COLS = DEF_COLS,
   parameter int ORIGIN_X = DEF_ORIGIN_X,
   parameter int ORIGIN_Y = DEF_ORIGIN_Y,
   parameter int B_WIDTH = DEF_B_WIDTH,
   parameter int B_HEIGHT = DEF_B_HEIGHT,
   parameter int GAP_X = DEF_GAP_X,
   parameter int GAP_Y = DEF_GAP_Y,
   parameter int BALL_SIZE = DEF_BALL_SIZE
) (
   input logic pclk,
   input logic rst_n,
   input logic frame_start,
   input logic level_load,
   input logic [CORD_W-1:0] ball_x,
   input logic [CORD_W-1:0] ball_y,
   brick_grid_collider_if.master hit,
   output logic scan_busy,
   output logic [ROWS*COLS-1:0] alive_mask,
   output logic [$clog2(ROWS*COLS+1)-1:0] bricks_left,
   output logic all_cleared
);
   localparam int N = ROWS * COLS;
   localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1;
   localparam int CW = COLS > 1 ? $clog2(COLS) : 1;
   localparam int NW = $clog2(N + 1);
   localparam int IW = N > 1 ? $clog2(N) : 1;
   state_t state, state_d;
   logic [CORD_W-1:0] bx_q, by_q, x0, y0;
   logic [RW-1:0] row, row_d;
   logic [CW-1:0] col, col_d;
   logic [IW-1:0] idx, hidx, hidx_d;
   logic [1:0] side_d;
   logic [N-1:0] alive_d;
   logic [NW-1:0] left_d;
   logic last, start, valid_d, ovl;
   logic [DEPTH_W-1:0] ax_lo, ax_hi, kx_lo, kx_hi, ay_lo, ay_hi, ky_lo, ky_hi, dx, dy;
   assign start = state == IDLE && frame_start && !level_load;
   brick_coord_gen #(
      .ROWS(ROWS), .COLS(COLS), .ORIGIN_X(ORIGIN_X), .ORIGIN_Y(ORIGIN_Y),
      .PITCH_X(B_WIDTH + GAP_X), .PITCH_Y(B_HEIGHT + GAP_Y), .RW(RW), .CW(CW), .IW(IW)
   ) u_coord (
      .pclk(pclk), .rst_n(rst_n), .start(start), .step(state == SCAN),
      .row(row), .col(col), .idx(idx), .x0(x0), .y0(y0), .last(last)
   );
   // one extra bit so ball/brick far edges near 4095 cannot wrap
   assign ax_lo = {1'b0, bx_q};
   assign ax_hi = ax_lo + DEPTH_W'(BALL_SIZE - 1);
   assign kx_lo = {1'b0, x0};
   assign kx_hi = kx_lo + DEPTH_W'(B_WIDTH);
   assign ay_lo = {1'b0, by_q};
   assign ay_hi = ay_lo + DEPTH_W'(BALL_SIZE - 1);
   assign ky_lo = {1'b0, y0};
   assign ky_hi = ky_lo + DEPTH_W'(B_HEIGHT);
   assign ovl = ax_lo <= kx_hi && ax_hi >= kx_lo && ay_lo <= ky_hi && ay_hi >= ky_lo;
   assign dx = (ax_hi < kx_hi ? ax_hi : kx_hi) - (ax_lo > kx_lo ? ax_lo : kx_lo) + DEPTH_W'(1);
   assign dy = (ay_hi < ky_hi ? ay_hi : ky_hi) - (ay_lo > ky_lo ? ay_lo : ky_lo) + DEPTH_W'(1);
   always_comb begin
      state_d = state;
      valid_d = hit.hit_valid;
      row_d = hit.hit_row;
      col_d = hit.hit_col;
      side_d = hit.hit_side;
      hidx_d = hidx;
      alive_d = alive_mask;
      left_d = bricks_left;
      if (level_load) begin
         state_d = IDLE;
         valid_d = 1'b0;
         alive_d = '1;
         left_d = NW'(N);
      end else begin
         case (state)
            IDLE: state_d = frame_start ? SCAN : IDLE;
            SCAN: begin
               if (alive_mask[idx] && ovl) begin
                  state_d = HIT;
                  valid_d = 1'b1;
                  row_d = row;
                  col_d = col;
                  side_d = side_of(dx, dy);
                  hidx_d = idx;
               end else if (last) state_d = IDLE;
            end
            HIT: begin
               if (hit.hit_ready) begin
                  state_d = IDLE;
                  valid_d = 1'b0;
                  alive_d[hidx] = 1'b0;
                  left_d = bricks_left == '0 ? '0 : bricks_left - NW'(1);
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         bx_q <= '0;
         by_q <= '0;
         hit.hit_valid <= 1'b0;
         hit.hit_row <= '0;
         hit.hit_col <= '0;
         hit.hit_side <= '0;
         hidx <= '0;
         alive_mask <= '1;
         bricks_left <= NW'(N);
         scan_busy <= 1'b0;
         all_cleared <= 1'b0;
      end else begin
         state <= state_d;
         bx_q <= start ? ball_x : bx_q;
         by_q <= start ? ball_y : by_q;
         hit.hit_valid <= valid_d;
         hit.hit_row <= row_d;
         hit.hit_col <= col_d;
         hit.hit_side <= side_d;
         hidx <= hidx_d;
         alive_mask <= alive_d;
         bricks_left <= left_d;
         scan_busy <= state_d != IDLE;
         all_cleared <= left_d == '0;
      end
   end
endmodule

// File: tb/tb_brick_grid_collider.sv
// tb_brick_grid_collider: directed checks of scan timing, hit reporting, level load and wall clearing
module tb_brick_grid_collider;
   logic pclk = 1'b0, rst_n = 1'b0;
   logic frame_start = 1'b0, level_load = 1'b0, fs2 = 1'b0, ll2 = 1'b0;
   logic [11:0] ball_x = '0, ball_y = '0;
   logic scan_busy, all_cleared, busy2, clr2;
   logic [15:0] alive_mask, mask2;
   logic [4:0] bricks_left, left2;
   int n_cmp = 0, n_bad = 0;
   brick_grid_collider_if #(.RW(2), .CW(2)) hit_if ();
   brick_grid_collider_if #(.RW(2), .CW(2)) hit2_if ();
   brick_grid_collider dut (
      .pclk(pclk), .rst_n(rst_n), .frame_start(frame_start), .level_load(level_load),
      .ball_x(ball_x), .ball_y(ball_y), .hit(hit_if.master), .scan_busy(scan_busy),
      .alive_mask(alive_mask), .bricks_left(bricks_left), .all_cleared(all_cleared)
   );
   brick_grid_collider #(.GAP_X(0)) dut2 (
      .pclk(pclk), .rst_n(rst_n), .frame_start(fs2), .level_load(ll2),
      .ball_x(ball_x), .ball_y(ball_y), .hit(hit2_if.master), .scan_busy(busy2),
      .alive_mask(mask2), .bricks_left(left2), .all_cleared(clr2)
   );
   always #5 pclk = ~pclk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge pclk);
      #1;
   endtask
   task automatic frame(input int x, input int y);
      ball_x = 12'(x);
      ball_y = 12'(y);
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
   endtask
   task automatic wait_idle(input string tag, output logic seen);
      int n;
      seen = 1'b0;
      n = 0;
      while (scan_busy && n < 40) begin
         seen |= hit_if.hit_valid;
         tick();
         n++;
      end
      check(tag, 32'(scan_busy), 32'd0);
   endtask
   initial begin
      logic seen;
      int k;
      hit_if.hit_ready = 1'b0;
      hit2_if.hit_ready = 1'b0;
      tick();
      tick();
      check("rst_mask", 32'(alive_mask), 32'hFFFF);
      check("rst_left", 32'(bricks_left), 32'd16);
      check("rst_valid", 32'(hit_if.hit_valid), 32'd0);
      check("rst_clear", 32'(all_cleared), 32'd0);
      check("rst_busy", 32'(scan_busy), 32'd0);
      rst_n = 1'b1;
      tick();
      frame(150, 106);
      check("t2_c1_valid", 32'(hit_if.hit_valid), 32'd0);
      check("t2_c1_busy", 32'(scan_busy), 32'd1);
      tick();
      check("t2_c2_valid", 32'(hit_if.hit_valid), 32'd1);
      check("t2_hit", {hit_if.hit_row, hit_if.hit_col, hit_if.hit_side}, 32'b00_00_01);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("t2_hold", {hit_if.hit_valid, hit_if.hit_row, hit_if.hit_col, hit_if.hit_side}, 32'b1_00_00_01);
      end
      hit_if.hit_ready = 1'b1;
      tick();
      hit_if.hit_ready = 1'b0;
      check("t2_ack_valid", 32'(hit_if.hit_valid), 32'd0);
      check("t2_mask", 32'(alive_mask), 32'hFFFE);
      check("t2_left", 32'(bricks_left), 32'd15);
      frame(150, 106);
      seen = 1'b0;
      for (int i = 1; i < 16; i++) begin
         seen |= hit_if.hit_valid;
         tick();
      end
      check("t3_c16_busy", 32'(scan_busy), 32'd1);
      tick();
      check("t3_c17_busy", 32'(scan_busy), 32'd0);
      check("t3_no_hit", 32'(seen | hit_if.hit_valid), 32'd0);
      frame(436, 130);
      for (int i = 1; i < 7; i++) tick();
      check("t4_c7_valid", 32'(hit_if.hit_valid), 32'd0);
      tick();
      check("t4_c8_valid", 32'(hit_if.hit_valid), 32'd1);
      check("t4_hit", {hit_if.hit_row, hit_if.hit_col, hit_if.hit_side}, 32'b01_10_10);
      hit_if.hit_ready = 1'b1;
      tick();
      hit_if.hit_ready = 1'b0;
      check("t4_mask", 32'(alive_mask), 32'hFFBE);
      check("t4_left", 32'(bricks_left), 32'd14);
      level_load = 1'b1;
      tick();
      level_load = 1'b0;
      check("ll_mask", 32'(alive_mask), 32'hFFFF);
      check("ll_left", 32'(bricks_left), 32'd16);
      frame(196, 106);
      tick();
      check("t5_hit", {hit_if.hit_valid, hit_if.hit_row, hit_if.hit_col, hit_if.hit_side}, 32'b1_00_00_11);
      level_load = 1'b1;
      tick();
      level_load = 1'b0;
      check("t6_ll_valid", 32'(hit_if.hit_valid), 32'd0);
      check("t6_ll_mask", 32'(alive_mask), 32'hFFFF);
      check("t6_ll_busy", 32'(scan_busy), 32'd0);
      level_load = 1'b1;
      frame(150, 106);
      level_load = 1'b0;
      check("ll_fs_busy", 32'(scan_busy), 32'd0);
      tick();
      check("ll_fs_valid", 32'(hit_if.hit_valid), 32'd0);
      ball_x = 12'd196;
      ball_y = 12'd90;
      fs2 = 1'b1;
      tick();
      fs2 = 1'b0;
      tick();
      check("gap0_hit", {hit2_if.hit_valid, hit2_if.hit_row, hit2_if.hit_col, hit2_if.hit_side}, 32'b1_00_00_10);
      hit2_if.hit_ready = 1'b1;
      tick();
      hit2_if.hit_ready = 1'b0;
      for (int i = 0; i < 18; i++) tick();
      check("gap0_mask", 32'(mask2), 32'hFFFE);
      check("gap0_idle", {31'd0, hit2_if.hit_valid | busy2}, 32'd0);
      hit_if.hit_ready = 1'b1;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            k = r * 4 + c;
            frame(146 + c * 120, 91 + r * 40);
            wait_idle("clr_timeout", seen);
            check("clr_rc", {hit_if.hit_row, hit_if.hit_col}, 32'(k));
         end
      end
      check("clr_mask", 32'(alive_mask), 32'h0000);
      check("clr_left", 32'(bricks_left), 32'd0);
      check("clr_all", 32'(all_cleared), 32'd1);
      frame(146, 91);
      wait_idle("post_timeout", seen);
      check("post_no_hit", 32'(seen), 32'd0);
      check("post_left", 32'(bricks_left), 32'd0);
      hit_if.hit_ready = 1'b0;
      level_load = 1'b1;
      tick();
      level_load = 1'b0;
      frame(150, 106);
      tick();
      check("ar_pre_valid", 32'(hit_if.hit_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      check("ar_valid", 32'(hit_if.hit_valid), 32'd0);
      check("ar_busy", 32'(scan_busy), 32'd0);
      check("ar_mask", 32'(alive_mask), 32'hFFFF);
      check("ar_left", 32'(bricks_left), 32'd16);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
